// File: rtl/reseller_pkg.sv
// Shared vending-machine definitions: dispenser states, coin select codes and
// the default money widths/denominations shared with the accumulator.
package reseller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_REQ,
        ST_RELEASE,
        ST_DONE,
        ST_FAULT
    } dispense_state_e;

    localparam logic [1:0] COIN_LO  = 2'd0;
    localparam logic [1:0] COIN_MID = 2'd1;
    localparam logic [1:0] COIN_HI  = 2'd2;

    localparam int MONEY_WIDTH_DEFAULT = 8;
    localparam int DEN_HI_DEFAULT      = 10;
    localparam int DEN_MID_DEFAULT     = 5;
    localparam int DEN_LO_DEFAULT      = 1;
    localparam int STOCK_INIT_DEFAULT  = 15;

endpackage

// File: rtl/change_dispenser_if.sv
// Payout request and coin-ejector handshake bundle for change_dispenser.
// master = vend logic / ejector side, slave = the dispenser itself.
interface change_dispenser_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] amount;
    logic             coin_ack;
    logic             coin_req;
    logic [1:0]       coin_sel;
    logic             busy;
    logic             done;
    logic             fault;
    logic [WIDTH-1:0] remaining;

    modport master (
        output start, amount, coin_ack,
        input  coin_req, coin_sel, busy, done, fault, remaining
    );

    modport slave (
        input  start, amount, coin_ack,
        output coin_req, coin_sel, busy, done, fault, remaining
    );
endinterface

// File: rtl/change_dispenser_coin_stock.sv
// coin_stock: inventory counter for one denomination. Loads the initial
// stock at reset, counts down once per dispensed coin, never wraps below 0.
module coin_stock #(
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic take_i,
    output logic empty_o
);
    logic [STOCK_W-1:0] count_q;

    // Stock register: reload on reset, decrement per coin, hold at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= STOCK_W'(STOCK_INIT);
        end else if (take_i && (count_q != '0)) begin
            count_q <= count_q - STOCK_W'(1);
        end
    end

    assign empty_o = (count_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: breaks a change amount greedily into HI/MID/LO coins and
// hands them to the ejector one at a time over a four-phase req/ack handshake.
// Define CHANGE_DISPENSER_INVENTORY_EN to track per-coin stock and report
// fault when the balance cannot be paid from what is left.
module change_dispenser
    import reseller_pkg::*;
#(
    parameter int WIDTH   = MONEY_WIDTH_DEFAULT,
    parameter int DEN_HI  = DEN_HI_DEFAULT,
    parameter int DEN_MID = DEN_MID_DEFAULT,
    parameter int DEN_LO  = DEN_LO_DEFAULT
`ifdef CHANGE_DISPENSER_INVENTORY_EN
    ,
    parameter int STOCK_INIT = STOCK_INIT_DEFAULT
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    change_dispenser_if.slave  bus
);
    localparam logic [WIDTH-1:0] DenHi  = WIDTH'(DEN_HI);
    localparam logic [WIDTH-1:0] DenMid = WIDTH'(DEN_MID);
    localparam logic [WIDTH-1:0] DenLo  = WIDTH'(DEN_LO);

    dispense_state_e  state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic [1:0]       coin_sel_q, coin_sel_d;
    logic [WIDTH-1:0] chosenVal;
    logic             hiAvail, midAvail, loAvail;

`ifdef CHANGE_DISPENSER_INVENTORY_EN
    localparam int StockW = (STOCK_INIT < 1) ? 1 : $clog2(STOCK_INIT + 1);

    logic ackTaken;
    logic hiEmpty, midEmpty, loEmpty;

    assign ackTaken = (state_q == ST_REQ) && bus.coin_ack;

    coin_stock #(.STOCK_W(StockW), .STOCK_INIT(STOCK_INIT)) u_stockHi (
        .clk(clk), .rst_n(rst_n),
        .take_i(ackTaken && (coin_sel_q == COIN_HI)), .empty_o(hiEmpty)
    );
    coin_stock #(.STOCK_W(StockW), .STOCK_INIT(STOCK_INIT)) u_stockMid (
        .clk(clk), .rst_n(rst_n),
        .take_i(ackTaken && (coin_sel_q == COIN_MID)), .empty_o(midEmpty)
    );
    coin_stock #(.STOCK_W(StockW), .STOCK_INIT(STOCK_INIT)) u_stockLo (
        .clk(clk), .rst_n(rst_n),
        .take_i(ackTaken && (coin_sel_q == COIN_LO)), .empty_o(loEmpty)
    );

    assign hiAvail  = !hiEmpty;
    assign midAvail = !midEmpty;
    assign loAvail  = !loEmpty;
`else
    assign hiAvail  = 1'b1;
    assign midAvail = 1'b1;
    assign loAvail  = 1'b1;
`endif

    // Value in money units of the coin currently offered to the ejector.
    always_comb begin
        chosenVal = DenLo;
        case (coin_sel_q)
            COIN_HI:  chosenVal = DenHi;
            COIN_MID: chosenVal = DenMid;
            default:  chosenVal = DenLo;
        endcase
    end

    // State, balance and selected coin registers; reset abandons any payout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            coin_sel_q  <= COIN_LO;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            coin_sel_q  <= coin_sel_d;
        end
    end

    // Next-state logic: greedy coin choice, handshake sequencing, completion.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        coin_sel_d  = coin_sel_q;
        case (state_q)
            ST_IDLE, ST_FAULT: begin
                if (bus.start) begin
                    remaining_d = bus.amount;
                    state_d     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (remaining_q == '0) begin
                    state_d = ST_DONE;
                end else if (hiAvail && (remaining_q >= DenHi)) begin
                    coin_sel_d = COIN_HI;
                    state_d    = ST_REQ;
                end else if (midAvail && (remaining_q >= DenMid)) begin
                    coin_sel_d = COIN_MID;
                    state_d    = ST_REQ;
                end else if (loAvail && (remaining_q >= DenLo)) begin
                    coin_sel_d = COIN_LO;
                    state_d    = ST_REQ;
                end else begin
`ifdef CHANGE_DISPENSER_INVENTORY_EN
                    state_d = ST_FAULT;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_REQ: begin
                if (bus.coin_ack) begin
                    remaining_d = remaining_q - chosenVal;
                    state_d     = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!bus.coin_ack) begin
                    state_d = ST_SELECT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.coin_req  = (state_q == ST_REQ);
    assign bus.coin_sel  = coin_sel_q;
    assign bus.busy      = (state_q == ST_SELECT) || (state_q == ST_REQ) ||
                           (state_q == ST_RELEASE) || (state_q == ST_DONE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.remaining = remaining_q;
`ifdef CHANGE_DISPENSER_INVENTORY_EN
    assign bus.fault     = (state_q == ST_FAULT);
`else
    assign bus.fault     = 1'b0;
`endif

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Pays change out of the vending machine: takes a change amount in the same money units the accumulator produces, breaks it greedily into coins, and drives a coin-ejector mechanism one coin at a time over a four-phase req/ack handshake. It sits downstream of the money accumulator and the vend logic. It exposes the remaining balance so the existing money display can show the payout counting down.

## Interface
- WIDTH, 8, bit width of amount/remaining (matches accumulator money width)
- DEN_HI, 10, value of large coin (money units)
- DEN_MID, 5, value of medium coin
- DEN_LO, 1, value of small coin
- STOCK_INIT, 15, per-denomination coin count loaded at reset (inventory build only)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- start  in  1  one-cycle request to pay `amount`; honoured only in IDLE
- amount  in  WIDTH  change to pay, latched on accepted start
- coin_ack  in  1  ejector acknowledge (four-phase)
- coin_req  out  1  ejector request; high while a coin is offered
- coin_sel  out  2  denomination of offered coin: 2'd2 HI, 2'd1 MID, 2'd0 LO
- busy  out  1  high from the cycle after accepted start until done pulse
- done  out  1  one-cycle pulse, payout complete
- fault  out  1  payout cannot complete (inventory build only; tied 0 otherwise)
- remaining  out  WIDTH  balance still to pay

## Operation
- Reset: state IDLE; coin_req=0, coin_sel=0, busy=0, done=0, fault=0, remaining=0; stock counters=STOCK_INIT.
- States: IDLE, SELECT, REQ, RELEASE, DONE, FAULT.
- IDLE: on start=1, remaining<=amount, go SELECT. start in any other state is ignored, and amount is not re-latched.
- SELECT (1 cycle):
  - remaining==0 -> DONE.
  - Otherwise pick the largest available denomination <= remaining, register coin_sel, go REQ.
- REQ: coin_req=1, coin_sel held stable. On coin_ack=1 sampled: remaining -= chosen value, coin_req<=0, go RELEASE.
- RELEASE: wait for coin_ack=0, then go SELECT. A new req is never raised while ack is still high.
- DONE: done=1 for one cycle, busy<=0, go IDLE. remaining is 0 here.
- FAULT (inventory build only):
  - fault=1, busy=0, remaining holds the unpaid balance.
  - Exit only by start, which clears fault and begins a new payout; or by reset.
- Arithmetic: the subtraction never underflows, because the chosen denomination is always <= remaining. No width extension is needed.
- Reset mid-operation returns to IDLE at that edge. coin_req drops at the same edge; the ejector must tolerate a withdrawn request.
- A coin_ack seen in IDLE, SELECT or DONE is ignored.

## Timing
- start sampled at edge N -> busy=1 and state SELECT after N; coin_req=1 after edge N+1.
- Per coin, minimum of 3 cycles: REQ (ack seen) -> RELEASE (ack low) -> SELECT.
- remaining updates on the edge that samples coin_ack=1.
- amount=0: done pulses 2 cycles after start (SELECT, DONE); no coin_req.
- done and start coinciding: start is ignored, because the state is DONE, not IDLE.

## Configuration
- CHANGE_DISPENSER_INVENTORY_EN defined:
  - Per-denomination stock counters, each decremented on ack of that coin.
  - SELECT skips any denomination whose stock is 0 and falls back to the next smaller one.
  - If remaining>0 and no denomination is usable, go FAULT.
  - Stock saturates at 0.
- Undefined: stock is treated as infinite, the FAULT state is unreachable, and fault is tied 0.

## Structure
- Shared package reseller_pkg holds:
  - the state enum;
  - coin_sel codes (COIN_LO/MID/HI);
  - default denomination constants, shared with the accumulator.
- Sub-module coin_stock:
  - one instance per denomination;
  - load at reset, decrement-on-strobe, empty flag;
  - instantiated only under the macro.

## Test plan
- amount=17, ack returned 2 cycles after each req -> coin_sel sequence 2,1,0,0; remaining 17->7->2->1->0; single done pulse; busy low afterwards.
- amount=0 -> done 2 cycles after start; coin_req never asserted.
- start with amount=30 issued during an ongoing payout of 6 -> ignored; only 6 is paid (coins 1,0).
- rst_n=0 while coin_req=1 with amount=12 -> next cycle coin_req=0, busy=0, remaining=0, state IDLE; a following start pays normally.
- Ack held high for 5 cycles after a coin -> no new coin_req until ack falls; exactly one decrement of remaining.
- Inventory build, HI stock forced to 0 (or 1 then consumed): amount=10 -> two MID coins.
  - With all stocks 0, amount=3 -> fault=1, remaining=3; a subsequent start clears fault.
